mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that funnels NUM_REQ requesters onto one
// memory-controller port, with a single transaction outstanding at a time.
// Each transaction walks IDLE -> ISSUE -> WAIT -> RESP; WAIT is bounded by
// TIMEOUT, and a timed-out transaction completes with resp_err.
module mem_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ-1:0]    req_wr,
    input  logic [NUM_REQ*32-1:0] req_addr,
    input  logic [NUM_REQ*32-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    resp_valid,
    output logic [31:0]           resp_data,
    output logic                  resp_err,
    output logic                  mc_rd_en,
    output logic                  mc_wr_en,
    output logic [31:0]           mc_addr,
    output logic [31:0]           mc_wdata,
    output logic                  mc_request_valid,
    input  logic                  mc_request_rdy,
    input  logic                  mc_done,
    input  logic [31:0]           mc_data,
    output logic                  busy,
    output logic [2:0]            grant_id
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t         r_state;
    logic [2:0]     r_prio_ptr;
    logic [2:0]     r_grant_id;
    logic           r_wr;
    logic [31:0]    r_addr;
    logic [31:0]    r_wdata;
    logic [31:0]    r_resp_data;
    logic           r_resp_err;
    logic [CW-1:0]  r_cnt;

    logic           w_hi_vld, w_lo_vld, w_win_vld;
    logic [2:0]     w_hi_idx, w_lo_idx, w_win_idx;
    logic           w_sel_wr;
    logic [31:0]    w_sel_addr, w_sel_wdata;

    // Round-robin pick: lowest valid index at or above the pointer, else the
    // lowest valid index overall (the scan wrapped past NUM_REQ-1).
    always_comb begin
        w_hi_vld = 1'b0;
        w_hi_idx = '0;
        w_lo_vld = 1'b0;
        w_lo_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                w_lo_vld = 1'b1;
                w_lo_idx = 3'(i);
                if (3'(i) >= r_prio_ptr) begin
                    w_hi_vld = 1'b1;
                    w_hi_idx = 3'(i);
                end
            end
        end
        w_win_vld = w_lo_vld;
        w_win_idx = w_hi_vld ? w_hi_idx : w_lo_idx;
    end

    // Mux the winner's command fields out of the flattened request buses.
    always_comb begin
        w_sel_wr    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (3'(i) == w_win_idx) begin
                w_sel_wr    = req_wr[i];
                w_sel_addr  = req_addr[32*i +: 32];
                w_sel_wdata = req_wdata[32*i +: 32];
            end
        end
    end

    // Transaction FSM; reset discards any in-flight transaction silently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_prio_ptr  <= '0;
            r_grant_id  <= '0;
            r_wr        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_win_vld) begin
                        r_grant_id <= w_win_idx;
                        r_wr       <= w_sel_wr;
                        r_addr     <= w_sel_addr;
                        r_wdata    <= w_sel_wdata;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (mc_request_rdy) begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // mc_done takes priority over a timeout landing in the same cycle
                    if (mc_done) begin
                        r_resp_data <= r_wr ? 32'h0 : mc_data;
                        r_resp_err  <= 1'b0;
                        r_state     <= S_RESP;
                    end else if (r_cnt == CW'(TIMEOUT)) begin
                        r_resp_data <= 32'h0;
                        r_resp_err  <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    r_prio_ptr  <= (r_grant_id == 3'(NUM_REQ - 1)) ? 3'd0 : r_grant_id + 3'd1;
                    r_resp_data <= '0;
                    r_resp_err  <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode straight off registered state; req_ready is also gated by
    // reset so every output reads 0 while rst is low.
    assign req_ready        = (rst && r_state == S_IDLE && w_win_vld) ? (ONE << w_win_idx) : '0;
    assign resp_valid       = (r_state == S_RESP) ? (ONE << r_grant_id) : '0;
    assign resp_data        = r_resp_data;
    assign resp_err         = r_resp_err;
    assign mc_request_valid = (r_state == S_ISSUE);
    assign mc_rd_en         = (r_state == S_ISSUE) && !r_wr;
    assign mc_wr_en         = (r_state == S_ISSUE) && r_wr;
    assign mc_addr          = r_addr;
    assign mc_wdata         = r_wdata;
    assign busy             = (r_state != S_IDLE);
    assign grant_id         = r_grant_id;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table of directed transactions, hand-written corner-case
// sequences (timeout, stalled issue, dropped request, reset mid-transaction)
// and randomized transactions checked against a round-robin reference model.
module tb_mem_arbiter;

    localparam int TIMEOUT = 255;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid, req_ready, req_wr, resp_valid;
    logic [127:0] req_addr, req_wdata;
    logic [31:0]  resp_data, mc_addr, mc_wdata, mc_data;
    logic         resp_err, mc_rd_en, mc_wr_en, mc_request_valid;
    logic         mc_request_rdy, mc_done, busy;
    logic [2:0]   grant_id;

    int checks = 0;
    int errors = 0;
    int txn_id = 0;
    int ptr    = 0;

    typedef struct {
        logic        rst_first;
        logic [3:0]  v;
        logic [3:0]  w;
        logic [31:0] d;
        int          g;
        logic [31:0] exp_d;
    } vec_t;

    vec_t tbl [11];

    mem_arbiter #(.NUM_REQ(4), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .mc_rd_en(mc_rd_en), .mc_wr_en(mc_wr_en), .mc_addr(mc_addr), .mc_wdata(mc_wdata),
        .mc_request_valid(mc_request_valid), .mc_request_rdy(mc_request_rdy),
        .mc_done(mc_done), .mc_data(mc_data), .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s txn %0d: got %h want %h", nm, txn_id, act, exp);
        end
    endtask

    // Reference arbiter: first valid index scanning p, p+1, ... modulo 4.
    function automatic int pick(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] oh(input int g);
        logic [3:0] r;
        r = 4'b0001 << g;
        return r;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'h0);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'h0);
        chk({tag, "_resp_data"}, resp_data, 32'h0);
        chk({tag, "_resp_err"}, 32'(resp_err), 32'h0);
        chk({tag, "_mc_cmd"}, 32'({mc_rd_en, mc_wr_en, mc_request_valid}), 32'h0);
        chk({tag, "_mc_addr"}, mc_addr, 32'h0);
        chk({tag, "_mc_wdata"}, mc_wdata, 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_grant"}, 32'(grant_id), 32'h0);
    endtask

    task automatic do_reset();
        req_valid = 4'b0000;
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        ptr = 0;
    endtask

    // One full transaction. rdy_dly = ISSUE cycles with rdy low before it rises;
    // done_dly = WAIT cycle index of mc_done, or <0 for never (timeout after
    // TIMEOUT+1 WAIT cycles).
    task automatic run_txn(input logic [3:0] vm, input logic [3:0] wm, input logic [31:0] dat,
                           input int rdy_dly, input int done_dly, input int exp_g,
                           input logic [31:0] exp_d, input logic exp_e);
        logic        wr;
        logic [31:0] ea, ew;
        int          wcyc;
        wr = wm[exp_g];
        ea = req_addr[32*exp_g +: 32];
        ew = req_wdata[32*exp_g +: 32];
        txn_id++;
        req_valid = vm; req_wr = wm; mc_request_rdy = 1'b0; mc_done = 1'b0; mc_data = dat;
        #1;
        chk("idle_ready", 32'(req_ready), 32'(oh(exp_g)));
        chk("idle_busy", 32'(busy), 32'h0);
        @(negedge clk);
        for (int c = 0; c <= rdy_dly; c++) begin
            mc_request_rdy = (c == rdy_dly);
            mc_done = 1'b1;
            #1;
            chk("iss_valid", 32'(mc_request_valid), 32'h1);
            chk("iss_rd", 32'(mc_rd_en), 32'(!wr));
            chk("iss_wr", 32'(mc_wr_en), 32'(wr));
            chk("iss_addr", mc_addr, ea);
            chk("iss_wdata", mc_wdata, ew);
            chk("iss_grant", 32'(grant_id), 32'(exp_g));
            chk("iss_ready", 32'(req_ready), 32'h0);
            chk("iss_resp", 32'(resp_valid), 32'h0);
            @(negedge clk);
        end
        mc_request_rdy = 1'b0;
        wcyc = (done_dly < 0) ? TIMEOUT + 1 : done_dly + 1;
        for (int c = 0; c < wcyc; c++) begin
            mc_done = (c == done_dly);
            #1;
            chk("wait_cmd", 32'({mc_rd_en, mc_wr_en, mc_request_valid}), 32'h0);
            chk("wait_addr", mc_addr, ea);
            chk("wait_resp", 32'(resp_valid), 32'h0);
            chk("wait_busy", 32'(busy), 32'h1);
            @(negedge clk);
        end
        mc_done = 1'b0;
        #1;
        chk("resp_valid", 32'(resp_valid), 32'(oh(exp_g)));
        chk("resp_data", resp_data, exp_d);
        chk("resp_err", 32'(resp_err), 32'(exp_e));
        @(negedge clk);
        ptr = (exp_g + 1) % 4;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 4'b0001, 4'b0000, 32'hDEADBEEF, 0, 32'hDEADBEEF};
        tbl[1]  = '{1'b1, 4'b1111, 4'b0000, 32'h11111111, 0, 32'h11111111};
        tbl[2]  = '{1'b0, 4'b1111, 4'b1111, 32'h22222222, 1, 32'h00000000};
        tbl[3]  = '{1'b0, 4'b1111, 4'b0000, 32'h33333333, 2, 32'h33333333};
        tbl[4]  = '{1'b0, 4'b1111, 4'b0000, 32'h44444444, 3, 32'h44444444};
        tbl[5]  = '{1'b0, 4'b1111, 4'b0000, 32'h55555555, 0, 32'h55555555};
        tbl[6]  = '{1'b0, 4'b1000, 4'b0000, 32'h66666666, 3, 32'h66666666};
        tbl[7]  = '{1'b0, 4'b1001, 4'b0000, 32'h77777777, 0, 32'h77777777};
        tbl[8]  = '{1'b0, 4'b0110, 4'b0110, 32'h88888888, 1, 32'h00000000};
        tbl[9]  = '{1'b0, 4'b0101, 4'b0101, 32'h99999999, 2, 32'h00000000};
        tbl[10] = '{1'b0, 4'b0011, 4'b0000, 32'hAAAAAAAA, 0, 32'hAAAAAAAA};

        // Reset state with every input active
        rst = 1'b0;
        req_valid = 4'b1111; req_wr = 4'b1111;
        req_addr  = {32'h310, 32'h210, 32'h110, 32'h010};
        req_wdata = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};
        mc_request_rdy = 1'b1; mc_done = 1'b1; mc_data = 32'hFFFFFFFF;
        @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;
        req_valid = 4'b0000;

        // Directed table: single read, round-robin order, pointer wrap
        for (int r = 0; r < 11; r++) begin
            if (tbl[r].rst_first) do_reset();
            run_txn(tbl[r].v, tbl[r].w, tbl[r].d, 0, 0, tbl[r].g, tbl[r].exp_d, 1'b0);
        end

        // Write to requester 2 that never completes -> timeout error
        run_txn(4'b0100, 4'b0100, 32'h12345678, 0, -1, pick(4'b0100, ptr), 32'h0, 1'b1);
        // mc_done on the final WAIT cycle beats the timeout
        run_txn(4'b1000, 4'b0000, 32'hCAFEF00D, 1, TIMEOUT, pick(4'b1000, ptr), 32'hCAFEF00D, 1'b0);
        // Controller stalls ISSUE for 10 cycles
        run_txn(4'b0001, 4'b0000, 32'h0C0FFEE0, 10, 0, pick(4'b0001, ptr), 32'h0C0FFEE0, 1'b0);

        // Request withdrawn before the clock edge is never granted
        req_valid = 4'b0100;
        #1;
        chk("drop_ready", 32'(req_ready), 32'(oh(pick(4'b0100, ptr))));
        #1 req_valid = 4'b0000;
        @(negedge clk);
        #1;
        chk("drop_busy", 32'(busy), 32'h0);
        chk("drop_grant", 32'(grant_id), 32'h0);
        chk("drop_cmd", 32'(mc_request_valid), 32'h0);
        @(negedge clk);
        run_txn(4'b0010, 4'b0000, 32'h5A5A5A5A, 0, 1, pick(4'b0010, ptr), 32'h5A5A5A5A, 1'b0);

        // Reset asserted in the middle of WAIT
        txn_id++;
        req_valid = 4'b0010; req_wr = 4'b0000; mc_request_rdy = 1'b1; mc_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        mc_request_rdy = 1'b0;
        @(negedge clk);
        #1 chk("rstw_busy_before", 32'(busy), 32'h1);
        req_valid = 4'b1111;
        #1 rst = 1'b0;
        #1 chk_all_zero("rstw");
        mc_done = 1'b1;
        @(negedge clk);
        #1 chk("rstw_resp_hold", 32'(resp_valid), 32'h0);
        mc_done = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        ptr = 0;
        run_txn(4'b1111, 4'b0000, 32'h0BADF00D, 0, 2, pick(4'b1111, ptr), 32'h0BADF00D, 1'b0);

        // Randomized transactions against the reference model
        for (int t = 0; t < 40; t++) begin
            logic [3:0]  vm, wm;
            logic [31:0] dat, ed;
            int          g, dd, rd;
            logic        to;
            vm = 4'($urandom_range(1, 15));
            wm = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                req_addr[32*i +: 32]  = $urandom;
                req_wdata[32*i +: 32] = $urandom;
            end
            dat = $urandom;
            rd  = int'($urandom_range(0, 3));
            dd  = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 6));
            g   = pick(vm, ptr);
            to  = (dd < 0);
            ed  = (wm[g] || to) ? 32'h0 : dat;
            run_txn(vm, wm, dat, rd, dd, g, ed, to);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
